dsram_like_responder: RTL and testbench

Slave end of the data sram-like interface driven by the MEM1 stage. Accepts address-phase requests (`req`/`addr_ok` handshake), performs the access on a local word-organised memory, and returns in-order data-phase responses (`data_ok`/`rdata`) after a fixed cached or uncached latency. Used as the data-side memory model in core-level simulation and as the on-chip data RAM behind the cache-bypass path.

---
 rtl/dsram_pkg.sv | 31 +++
 rtl/dsram_like_responder_resp_queue.sv | 58 +++++
 rtl/dsram_like_responder.sv | 78 +++++++
 tb/tb_dsram_like_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsram_pkg.sv
// Shared constants and response-entry type for the data sram-like responder.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package dsram_pkg;

    // Access size encodings carried on the size port (informational only).
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Default latencies; the countdown field is sized from these, so any
    // instance needing longer latencies must raise them here.
    localparam int LAT_DEF    = 2;
    localparam int UC_LAT_DEF = 4;

    // The countdown holds lat-1, so ceil(log2(max lat)) bits are enough.
    function automatic int cnt_width(input int lat, input int uc_lat);
        int m;
        m = (lat > uc_lat) ? lat : uc_lat;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    localparam int CNT_W = cnt_width(LAT_DEF, UC_LAT_DEF);

    typedef struct packed {
        logic             wr;
        logic [31:0]      data;
        logic [CNT_W-1:0] count;
    } resp_entry_t;

endpackage

// File: rtl/dsram_like_responder_resp_queue.sv
// In-order response FIFO with a per-entry saturating countdown to readiness.
// Latency: an entry pushed with count N is head-ready N+1 cycles later at the earliest.
// Backpressure: full when QDEPTH entries held; a pop does not free a slot the same cycle.
module resp_queue
    import dsram_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_wr,
    input  logic [31:0]      push_data,
    input  logic [CNT_W-1:0] push_count,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             head_ready,
    output logic             head_wr,
    output logic [31:0]      head_data
);

    localparam int QW = $clog2(QDEPTH);
    localparam logic [QW:0] OCC_FULL = (QW+1)'(QDEPTH);

    resp_entry_t   ent [QDEPTH];
    logic [QW-1:0] rptr;
    logic [QW-1:0] wptr;
    logic [QW:0]   occ;

    assign full       = (occ == OCC_FULL);
    assign empty      = (occ == '0);
    assign head_ready = !empty && (ent[rptr].count == '0);
    assign head_wr    = ent[rptr].wr;
    assign head_data  = ent[rptr].data;

    // Pointer and occupancy bookkeeping; reset discards everything outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr <= '0;
            wptr <= '0;
            occ  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            occ <= occ + (QW+1)'(push) - (QW+1)'(pop);
        end
    end

    // Entry storage: every slot counts down to zero, a push overwrites its slot.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (ent[i].count != '0) ent[i].count <= ent[i].count - 1'b1;
        end
        if (push) ent[wptr] <= '{wr: push_wr, data: push_data, count: push_count};
    end

endmodule

// File: rtl/dsram_like_responder.sv
// Data-side sram-like slave: word memory with strobed writes and in-order responses.
// Latency: data_ok LAT (cached) or UC_LAT (uncached) cycles after acceptance, in order.
// Backpressure: addr_ok drops on reset, hold, or QDEPTH requests outstanding.
module dsram_like_responder
    import dsram_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int LAT    = LAT_DEF,
    parameter int UC_LAT = UC_LAT_DEF,
    parameter int QDEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        uncache,
    input  logic        hold,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] UC_CNT  = CNT_W'(UC_LAT - 1);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic          xfer;
    logic          q_full;
    logic          q_empty;
    logic          q_ready;
    logic          head_wr;
    logic [31:0]   head_data;
    logic          unused_bits;

    // Word index wraps modulo DEPTH; size only tells the requester which bytes it wants.
    assign idx         = addr[AW+1:2];
    assign unused_bits = ^{size, addr[31:AW+2], addr[1:0], q_empty};

    assign addr_ok = !reset && !hold && !q_full;
    assign xfer    = req && addr_ok;
    assign data_ok = q_ready;
    assign rdata   = (data_ok && !head_wr) ? head_data : 32'd0;
    assign rd_word = mem[idx];

    // Byte-lane write at the transfer edge; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (xfer && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    resp_queue #(
        .QDEPTH (QDEPTH)
    ) u_resp_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (xfer),
        .push_wr    (wr),
        .push_data  (wr ? 32'd0 : rd_word),
        .push_count (uncache ? UC_CNT : LAT_CNT),
        .pop        (q_ready),
        .full       (q_full),
        .empty      (q_empty),
        .head_ready (q_ready),
        .head_wr    (head_wr),
        .head_data  (head_data)
    );

endmodule

// File: tb/tb_dsram_like_responder.sv
// Directed bench for dsram_like_responder with per-cycle hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Each scenario task owns its vector table and its comparisons.
module tb_dsram_like_responder;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        uncache;
    logic        hold;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // One cycle of stimulus plus the outputs expected in that cycle.
    typedef struct {
        logic        rst;
        logic        rq;
        logic        w;
        logic        unc;
        logic        hld;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
        logic        e_aok;
        logic        e_dok;
        logic [31:0] e_rd;
    } vec_t;

    dsram_like_responder dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr      (wr),
        .size    (size),
        .wstrb   (wstrb),
        .addr    (addr),
        .wdata   (wdata),
        .uncache (uncache),
        .hold    (hold),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .rdata   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input vec_t v);
        reset   = v.rst;
        req     = v.rq;
        wr      = v.w;
        uncache = v.unc;
        hold    = v.hld;
        addr    = v.a;
        wdata   = v.wd;
        wstrb   = v.st;
        size    = 2'd2;
    endtask

    task automatic test_reset();
        vec_t v [3];
        v = '{'{H,H,L,L,L,32'h100,32'h0,4'h0,L,L,32'h0},
              '{H,H,H,L,L,32'h100,32'h0,4'hF,L,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0}};
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            n_checks++; if (addr_ok !== v[i].e_aok) begin n_fail++; $display("FAIL reset[%0d] addr_ok got %b want %b", i, addr_ok, v[i].e_aok); end
            n_checks++; if (data_ok !== v[i].e_dok) begin n_fail++; $display("FAIL reset[%0d] data_ok got %b want %b", i, data_ok, v[i].e_dok); end
            n_checks++; if (rdata !== v[i].e_rd) begin n_fail++; $display("FAIL reset[%0d] rdata got %h want %h", i, rdata, v[i].e_rd); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_word_rw();
        vec_t v [5];
        v = '{'{L,H,H,L,L,32'h100,32'hDEADBEEF,4'hF,H,L,32'h0},
              '{L,H,L,L,L,32'h100,32'h0,4'h0,H,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'hDEADBEEF},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0}};
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            n_checks++; if (addr_ok !== v[i].e_aok) begin n_fail++; $display("FAIL word_rw[%0d] addr_ok got %b want %b", i, addr_ok, v[i].e_aok); end
            n_checks++; if (data_ok !== v[i].e_dok) begin n_fail++; $display("FAIL word_rw[%0d] data_ok got %b want %b", i, data_ok, v[i].e_dok); end
            n_checks++; if (rdata !== v[i].e_rd) begin n_fail++; $display("FAIL word_rw[%0d] rdata got %h want %h", i, rdata, v[i].e_rd); end
            @(posedge clk); #1;
        end
    endtask

    // Lane 1 strobe only; other lanes carry junk that must not land. 0x1100 aliases 0x100.
    task automatic test_byte_strobe();
        vec_t v [7];
        v = '{'{L,H,H,L,L,32'h100,32'h11223344,4'hF,H,L,32'h0},
              '{L,H,H,L,L,32'h101,32'h5555AA55,4'h2,H,L,32'h0},
              '{L,H,L,L,L,32'h101,32'h0,4'h0,H,H,32'h0},
              '{L,H,L,L,L,32'h1100,32'h0,4'h0,H,H,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'h1122AA44},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'h1122AA44},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0}};
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            n_checks++; if (addr_ok !== v[i].e_aok) begin n_fail++; $display("FAIL byte_strobe[%0d] addr_ok got %b want %b", i, addr_ok, v[i].e_aok); end
            n_checks++; if (data_ok !== v[i].e_dok) begin n_fail++; $display("FAIL byte_strobe[%0d] data_ok got %b want %b", i, data_ok, v[i].e_dok); end
            n_checks++; if (rdata !== v[i].e_rd) begin n_fail++; $display("FAIL byte_strobe[%0d] rdata got %h want %h", i, rdata, v[i].e_rd); end
            @(posedge clk); #1;
        end
    endtask

    // Uncached read then cached read: the younger one is ready first but waits.
    task automatic test_uncache_order();
        vec_t v [10];
        v = '{'{L,H,H,L,L,32'h200,32'hCAFEF00D,4'hF,H,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'h0},
              '{L,H,L,H,L,32'h100,32'h0,4'h0,H,L,32'h0},
              '{L,H,L,L,L,32'h200,32'h0,4'h0,H,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'h1122AA44},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'hCAFEF00D},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0}};
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            n_checks++; if (addr_ok !== v[i].e_aok) begin n_fail++; $display("FAIL uncache_order[%0d] addr_ok got %b want %b", i, addr_ok, v[i].e_aok); end
            n_checks++; if (data_ok !== v[i].e_dok) begin n_fail++; $display("FAIL uncache_order[%0d] data_ok got %b want %b", i, data_ok, v[i].e_dok); end
            n_checks++; if (rdata !== v[i].e_rd) begin n_fail++; $display("FAIL uncache_order[%0d] rdata got %h want %h", i, rdata, v[i].e_rd); end
            @(posedge clk); #1;
        end
    endtask

    // Six uncached requests: queue fills after four, reopens the cycle after the first pop.
    task automatic test_full();
        vec_t v [12];
        v = '{'{L,H,L,H,L,32'h100,32'h0,4'h0,H,L,32'h0},
              '{L,H,H,H,L,32'h300,32'h01020304,4'hF,H,L,32'h0},
              '{L,H,L,H,L,32'h300,32'h0,4'h0,H,L,32'h0},
              '{L,H,L,H,L,32'h200,32'h0,4'h0,H,L,32'h0},
              '{L,H,H,H,L,32'h300,32'hFF000000,4'h8,L,H,32'h1122AA44},
              '{L,H,H,H,L,32'h300,32'hFF000000,4'h8,H,H,32'h0},
              '{L,H,L,H,L,32'h300,32'h0,4'h0,H,H,32'h01020304},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'hCAFEF00D},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'hFF020304},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0}};
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            n_checks++; if (addr_ok !== v[i].e_aok) begin n_fail++; $display("FAIL full[%0d] addr_ok got %b want %b", i, addr_ok, v[i].e_aok); end
            n_checks++; if (data_ok !== v[i].e_dok) begin n_fail++; $display("FAIL full[%0d] data_ok got %b want %b", i, data_ok, v[i].e_dok); end
            n_checks++; if (rdata !== v[i].e_rd) begin n_fail++; $display("FAIL full[%0d] rdata got %h want %h", i, rdata, v[i].e_rd); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold();
        vec_t v [7];
        v = '{'{L,H,L,L,H,32'h100,32'h0,4'h0,L,L,32'h0},
              '{L,H,L,L,H,32'h100,32'h0,4'h0,L,L,32'h0},
              '{L,H,L,L,H,32'h100,32'h0,4'h0,L,L,32'h0},
              '{L,H,L,L,L,32'h100,32'h0,4'h0,H,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'h1122AA44},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0}};
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            n_checks++; if (addr_ok !== v[i].e_aok) begin n_fail++; $display("FAIL hold[%0d] addr_ok got %b want %b", i, addr_ok, v[i].e_aok); end
            n_checks++; if (data_ok !== v[i].e_dok) begin n_fail++; $display("FAIL hold[%0d] data_ok got %b want %b", i, data_ok, v[i].e_dok); end
            n_checks++; if (rdata !== v[i].e_rd) begin n_fail++; $display("FAIL hold[%0d] rdata got %h want %h", i, rdata, v[i].e_rd); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [7];
        v = '{'{L,H,L,L,L,32'h100,32'h0,4'h0,H,L,32'h0},
              '{L,H,L,L,L,32'h200,32'h0,4'h0,H,L,32'h0},
              '{L,H,L,L,L,32'h300,32'h0,4'h0,H,H,32'h1122AA44},
              '{L,H,L,L,L,32'h100,32'h0,4'h0,H,H,32'hCAFEF00D},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'hFF020304},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'h1122AA44},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0}};
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            n_checks++; if (addr_ok !== v[i].e_aok) begin n_fail++; $display("FAIL back_to_back[%0d] addr_ok got %b want %b", i, addr_ok, v[i].e_aok); end
            n_checks++; if (data_ok !== v[i].e_dok) begin n_fail++; $display("FAIL back_to_back[%0d] data_ok got %b want %b", i, data_ok, v[i].e_dok); end
            n_checks++; if (rdata !== v[i].e_rd) begin n_fail++; $display("FAIL back_to_back[%0d] rdata got %h want %h", i, rdata, v[i].e_rd); end
            @(posedge clk); #1;
        end
    endtask

    // Three uncached reads in flight when reset hits; the oldest would have answered in row 4.
    task automatic test_reset_midburst();
        vec_t v [10];
        v = '{'{L,H,L,H,L,32'h100,32'h0,4'h0,H,L,32'h0},
              '{L,H,L,H,L,32'h200,32'h0,4'h0,H,L,32'h0},
              '{L,H,L,H,L,32'h300,32'h0,4'h0,H,L,32'h0},
              '{H,H,L,L,L,32'h100,32'h0,4'h0,L,L,32'h0},
              '{L,H,L,L,L,32'h200,32'h0,4'h0,H,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,H,32'hCAFEF00D},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0},
              '{L,L,L,L,L,32'h0,32'h0,4'h0,H,L,32'h0}};
        foreach (v[i]) begin
            apply(v[i]);
            @(negedge clk);
            n_checks++; if (addr_ok !== v[i].e_aok) begin n_fail++; $display("FAIL reset_midburst[%0d] addr_ok got %b want %b", i, addr_ok, v[i].e_aok); end
            n_checks++; if (data_ok !== v[i].e_dok) begin n_fail++; $display("FAIL reset_midburst[%0d] data_ok got %b want %b", i, data_ok, v[i].e_dok); end
            n_checks++; if (rdata !== v[i].e_rd) begin n_fail++; $display("FAIL reset_midburst[%0d] rdata got %h want %h", i, rdata, v[i].e_rd); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset   = 1'b1;
        req     = 1'b0;
        wr      = 1'b0;
        size    = 2'd2;
        wstrb   = 4'h0;
        addr    = 32'h0;
        wdata   = 32'h0;
        uncache = 1'b0;
        hold    = 1'b0;
        test_reset();
        test_word_rw();
        test_byte_strobe();
        test_uncache_order();
        test_full();
        test_hold();
        test_back_to_back();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
